// File: rtl/lpf_ctrl_pkg.sv
// Shared types and constants for the PLL loop-filter sequencer.
package lpf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    ACQUIRE = 2'd2,
    TRACK   = 2'd3
  } state_t;

  localparam logic GAIN_FAST = 1'b0;
  localparam logic GAIN_SLOW = 1'b1;

  localparam int SCAN_LEN = 32;

  // Width of a counter that must reach n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lock_window_mon.sv
// Fixed-length window counter plus PFD event counter; flags the window
// verdict combinationally in its last cycle so the event in that cycle counts.
module lock_window_mon
  import lpf_ctrl_pkg::*;
#(
  parameter int WIN_LEN  = 64,
  parameter int GOOD_THR = 4,
  parameter int BAD_THR  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic pd_event,
  output logic window_done,
  output logic good,
  output logic bad
);

  localparam int WW = $clog2(WIN_LEN);
  localparam int EW = cnt_width(WIN_LEN);
  localparam logic [EW-1:0] GOOD_LIM = EW'(GOOD_THR);
  localparam logic [EW-1:0] BAD_LIM  = EW'(BAD_THR);

  logic [WW-1:0] win_cnt;
  logic [EW-1:0] evt_cnt;
  logic [EW-1:0] evt_total;

  assign evt_total   = evt_cnt + EW'(pd_event);
  assign window_done = (win_cnt == WW'(WIN_LEN - 1)) && !clear;
  assign good        = (evt_total <= GOOD_LIM);
  assign bad         = (evt_total > BAD_LIM);

  // WIN_LEN is a power of two, so the window counter wraps on its own.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      win_cnt <= '0;
      evt_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + WW'(1);
      if (window_done) evt_cnt <= '0;
      else             evt_cnt <= evt_total;
    end
  end

endmodule

// File: rtl/lpf_seq_ctrl.sv
// Loop-filter sequencer: scan preload/readback of the phase accumulator and
// window-based lock detection driving the filter gain select.
module lpf_seq_ctrl
  import lpf_ctrl_pkg::*;
#(
  parameter int WIN_LEN  = 64,
  parameter int GOOD_THR = 4,
  parameter int BAD_THR  = 16,
  parameter int N_GOOD   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        cfg_load,
  input  logic [31:0] cfg_word,
  output logic        scan_en,
  output logic        scan_in,
  input  logic        scan_out,
  output logic [31:0] readback_word,
  output logic        readback_valid,
  output logic        gain_sel,
  output logic        locked,
  output logic        lock_lost,
  output logic        busy
);

  localparam int SW = $clog2(SCAN_LEN);
  localparam int GW = cnt_width(N_GOOD);

  state_t              state;
  logic [SW-1:0]       scan_cnt;
  logic [SCAN_LEN-1:0] scan_sr;
  logic [SCAN_LEN-1:0] rb_sr;
  logic [GW-1:0]       good_cnt;

  logic pd_event;
  logic mon_clear;
  logic window_done;
  logic win_good;
  logic win_bad;

  // Both pulses high means zero phase error, same as the filter sees it.
  assign pd_event  = up ^ down;
  assign mon_clear = (state == IDLE) || (state == SHIFT);

  lock_window_mon #(
    .WIN_LEN (WIN_LEN),
    .GOOD_THR(GOOD_THR),
    .BAD_THR (BAD_THR)
  ) u_mon (
    .clk        (clk),
    .rst        (rst),
    .clear      (mon_clear),
    .pd_event   (pd_event),
    .window_done(window_done),
    .good       (win_good),
    .bad        (win_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      scan_cnt       <= '0;
      scan_sr        <= '0;
      rb_sr          <= '0;
      good_cnt       <= '0;
      scan_en        <= 1'b0;
      scan_in        <= 1'b0;
      readback_word  <= '0;
      readback_valid <= 1'b0;
      gain_sel       <= GAIN_FAST;
      locked         <= 1'b0;
      lock_lost      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      readback_valid <= 1'b0;
      lock_lost      <= 1'b0;
      // A preload request overrides any window decision in the same cycle.
      if (cfg_load && state != SHIFT) begin
        state    <= SHIFT;
        scan_en  <= 1'b1;
        busy     <= 1'b1;
        scan_in  <= cfg_word[SCAN_LEN-1];
        scan_sr  <= {cfg_word[SCAN_LEN-2:0], 1'b0};
        scan_cnt <= '0;
        rb_sr    <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
        gain_sel <= GAIN_FAST;
      end else begin
        case (state)
          SHIFT: begin
            rb_sr    <= {rb_sr[SCAN_LEN-2:0], scan_out};
            scan_sr  <= {scan_sr[SCAN_LEN-2:0], 1'b0};
            scan_in  <= scan_sr[SCAN_LEN-1];
            scan_cnt <= scan_cnt + SW'(1);
            if (scan_cnt == SW'(SCAN_LEN - 1)) begin
              state          <= ACQUIRE;
              scan_en        <= 1'b0;
              busy           <= 1'b0;
              scan_in        <= 1'b0;
              readback_word  <= {rb_sr[SCAN_LEN-2:0], scan_out};
              readback_valid <= 1'b1;
              good_cnt       <= '0;
              gain_sel       <= GAIN_FAST;
            end
          end
          ACQUIRE: begin
            if (window_done) begin
              if (win_good) begin
                if (good_cnt == GW'(N_GOOD - 1)) begin
                  state    <= TRACK;
                  good_cnt <= '0;
                  gain_sel <= GAIN_SLOW;
                  locked   <= 1'b1;
                end else begin
                  good_cnt <= good_cnt + GW'(1);
                end
              end else begin
                good_cnt <= '0;
              end
            end
          end
          TRACK: begin
            if (window_done && win_bad) begin
              state     <= ACQUIRE;
              good_cnt  <= '0;
              gain_sel  <= GAIN_FAST;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpf_seq_ctrl.sv
// Randomized self-checking bench for lpf_seq_ctrl with a scan-chain filter
// model and a window-level lock reference model.
module tb_lpf_seq_ctrl;

  localparam int WIN = 64;
  localparam int GT  = 4;
  localparam int BT  = 16;
  localparam int NG  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic        cfg_load = 1'b0;
  logic [31:0] cfg_word = '0;
  logic        scan_en;
  logic        scan_in;
  logic        scan_out;
  logic [31:0] readback_word;
  logic        readback_valid;
  logic        gain_sel;
  logic        locked;
  logic        lock_lost;
  logic        busy;

  logic [31:0] acc = '0;
  logic [31:0] fm_val = '0;
  logic        fm_load = 1'b0;

  int errors = 0;
  int checks = 0;
  bit m_locked = 1'b0;
  int m_good = 0;

  lpf_seq_ctrl #(.WIN_LEN(WIN), .GOOD_THR(GT), .BAD_THR(BT), .N_GOOD(NG)) dut (
    .clk           (clk),
    .rst           (rst),
    .up            (up),
    .down          (down),
    .cfg_load      (cfg_load),
    .cfg_word      (cfg_word),
    .scan_en       (scan_en),
    .scan_in       (scan_in),
    .scan_out      (scan_out),
    .readback_word (readback_word),
    .readback_valid(readback_valid),
    .gain_sel      (gain_sel),
    .locked        (locked),
    .lock_lost     (lock_lost),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Loop-filter accumulator scan chain: shifts left, scan_out is the MSB.
  always @(posedge clk) begin
    if (fm_load)      acc <= fm_val;
    else if (scan_en) acc <= {acc[30:0], scan_in};
  end
  assign scan_out = acc[31];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_issue(input logic [31:0] w, input logic [31:0] old);
    cfg_load = 1'b1;
    cfg_word = w;
    fm_val   = old;
    fm_load  = 1'b1;
    step();
    cfg_load = 1'b0;
    fm_load  = 1'b0;
  endtask

  // Entered in the first shift cycle; returns in the first ACQUIRE cycle.
  task automatic shift_check(input logic [31:0] w, input logic [31:0] old, input int ignore_at);
    bit bad_cyc = 1'b0;
    int en_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      if (scan_en === 1'b1) en_cnt++;
      if (scan_en !== 1'b1 || busy !== 1'b1 || scan_in !== w[31-k] ||
          readback_valid !== 1'b0 || locked !== 1'b0 || lock_lost !== 1'b0)
        bad_cyc = 1'b1;
      cfg_load = (k == ignore_at);
      cfg_word = ~w;
      up   = 1'($urandom_range(1, 0));
      down = 1'($urandom_range(1, 0));
      step();
    end
    cfg_load = 1'b0;
    up = 1'b0;
    down = 1'b0;
    checks++;
    if (bad_cyc || en_cnt != 32) begin
      errors++;
      $display("FAIL shift_cycles: scan_en high %0d cycles, cycle mismatch=%0d, want 32 and 0", en_cnt, bad_cyc);
    end
    checks++;
    if (scan_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL shift_end: scan_en=%b busy=%b want 0 0", scan_en, busy);
    end
    checks++;
    if (readback_valid !== 1'b1 || readback_word !== old) begin
      errors++;
      $display("FAIL readback: valid=%b word=%h want 1 %h", readback_valid, readback_word, old);
    end
    checks++;
    if (acc !== w) begin
      errors++;
      $display("FAIL filter_acc: got %h want %h", acc, w);
    end
    m_locked = 1'b0;
    m_good   = 0;
  endtask

  task automatic preload(input logic [31:0] w, input logic [31:0] old, input int ignore_at);
    preload_issue(w, old);
    shift_check(w, old, ignore_at);
  endtask

  // Drives one full window with exactly n events, then checks the verdict.
  // kind: 0 mixed up/down events, 1 up-only events, 2 non-events are both-high.
  task automatic run_window(input int n, input int kind, input bit load_last,
                            input logic [31:0] lw, input logic [31:0] lold);
    bit pos[WIN];
    bit mid_bad = 1'b0;
    bit pre = m_locked;
    bit exp_lost = 1'b0;
    bit t;
    int j;
    for (int i = 0; i < WIN; i++) pos[i] = (i < n);
    for (int i = WIN - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = pos[i]; pos[i] = pos[j]; pos[j] = t;
    end
    if (kind == 1 && n > 0 && !pos[WIN-1]) begin
      for (int i = 0; i < WIN - 1; i++)
        if (pos[i] && !pos[WIN-1]) begin
          pos[i] = 1'b0;
          pos[WIN-1] = 1'b1;
        end
    end
    for (int i = 0; i < WIN; i++) begin
      if (pos[i]) begin
        if (kind == 1 || $urandom_range(1, 0) == 1) begin up = 1'b1; down = 1'b0; end
        else begin up = 1'b0; down = 1'b1; end
      end else if (kind == 2) begin
        up = 1'b1; down = 1'b1;
      end else begin
        up = 1'($urandom_range(1, 0));
        down = up;
      end
      if (load_last && i == WIN - 1) begin
        cfg_load = 1'b1;
        cfg_word = lw;
        fm_val   = lold;
        fm_load  = 1'b1;
      end
      step();
      if (i < WIN - 1)
        if (locked !== pre || gain_sel !== pre || lock_lost !== 1'b0 || readback_valid !== 1'b0)
          mid_bad = 1'b1;
    end
    cfg_load = 1'b0;
    fm_load  = 1'b0;
    up = 1'b0;
    down = 1'b0;
    checks++;
    if (mid_bad) begin
      errors++;
      $display("FAIL mid_window: outputs changed before window end, locked before=%0d", pre);
    end
    if (load_last) begin
      m_locked = 1'b0;
      m_good = 0;
    end else if (!m_locked) begin
      if (n <= GT) begin
        m_good++;
        if (m_good == NG) begin m_locked = 1'b1; m_good = 0; end
      end else begin
        m_good = 0;
      end
    end else if (n > BT) begin
      m_locked = 1'b0;
      m_good = 0;
      exp_lost = 1'b1;
    end
    checks++;
    if (locked !== m_locked || gain_sel !== m_locked) begin
      errors++;
      $display("FAIL window_lock n=%0d: locked=%b gain_sel=%b want %b %b", n, locked, gain_sel, m_locked, m_locked);
    end
    checks++;
    if (lock_lost !== exp_lost) begin
      errors++;
      $display("FAIL window_lost n=%0d: lock_lost=%b want %b", n, lock_lost, exp_lost);
    end
    if (load_last) begin
      checks++;
      if (scan_en !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL load_wins: scan_en=%b busy=%b want 1 1", scan_en, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({scan_en, scan_in, readback_valid, gain_sel, locked, lock_lost, busy} !== 7'b0 ||
        readback_word !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: en=%b in=%b rv=%b rw=%h gs=%b lk=%b ll=%b busy=%b want all 0",
               scan_en, scan_in, readback_valid, readback_word, gain_sel, locked, lock_lost, busy);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_preload();
    preload(32'hA5C3_1E0F, 32'h1234_5678, 5);
  endtask

  task automatic test_quiet_lock();
    for (int w = 0; w < NG; w++) run_window(0, 0, 1'b0, '0, '0);
  endtask

  task automatic test_bad_window();
    run_window(16, 1, 1'b0, '0, '0);
    run_window(17, 1, 1'b0, '0, '0);
  endtask

  task automatic test_alternating();
    for (int w = 0; w < 12; w++) run_window((w % 2 == 0) ? 3 : 5, 0, 1'b0, '0, '0);
    for (int w = 0; w < NG; w++) run_window(GT, 0, 1'b0, '0, '0);
  endtask

  task automatic test_load_vs_decision();
    logic [31:0] w2;
    logic [31:0] o2;
    w2 = $urandom;
    o2 = $urandom;
    run_window(17, 1, 1'b1, w2, o2);
    shift_check(w2, o2, -1);
  endtask

  task automatic test_both_high();
    for (int w = 0; w < NG; w++) run_window(0, 2, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    int good_opts[4] = '{0, 2, 3, 4};
    int other_opts[6] = '{5, 6, 15, 16, 17, 30};
    for (int w = 0; w < 24; w++) begin
      if ($urandom_range(9, 0) < 7)
        run_window(good_opts[$urandom_range(3, 0)], 0, 1'b0, '0, '0);
      else
        run_window(other_opts[$urandom_range(5, 0)], 0, 1'b0, '0, '0);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit bad_idle = 1'b0;
    preload_issue(32'hDEAD_BEEF, 32'h0F0F_0F0F);
    repeat (9) step();
    rst = 1'b1;
    step();
    checks++;
    if ({scan_en, scan_in, readback_valid, gain_sel, locked, lock_lost, busy} !== 7'b0 ||
        readback_word !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_shift: en=%b in=%b rv=%b rw=%h gs=%b lk=%b ll=%b busy=%b want all 0",
               scan_en, scan_in, readback_valid, readback_word, gain_sel, locked, lock_lost, busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (readback_valid !== 1'b0 || scan_en !== 1'b0 || busy !== 1'b0) bad_idle = 1'b1;
    end
    checks++;
    if (bad_idle) begin
      errors++;
      $display("FAIL post_reset_idle: readback_valid or scan_en seen high, want 0");
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_quiet_lock();
    test_bad_window();
    test_alternating();
    test_load_vs_decision();
    test_both_high();
    test_random();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lpf_seq_ctrl.md
# lpf_seq_ctrl

Sequencer for the PLL loop filter. Preloads and reads back the filter's 32-bit phase accumulator over its scan chain, and monitors the phase detector's up/down pulses in fixed windows. From that it decides when the loop has acquired lock. It drives a gain-select to the filter (fast gains for acquisition, slow for tracking) and sits between the phase-frequency detector and the loop filter.

## Interface
Parameters:
- WIN_LEN, 64: cycles per lock-detect window (power of two, ≥ 8)
- GOOD_THR, 4: a window is "good" if its event count ≤ GOOD_THR
- BAD_THR, 16: a window is "bad" if its event count > BAD_THR
- N_GOOD, 8: consecutive good windows required to declare lock

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- up  in  1  PFD up pulse (same signal fed to filter)
- down  in  1  PFD down pulse
- cfg_load  in  1  one-cycle request to preload the accumulator
- cfg_word  in  32  preload value, sampled when cfg_load accepted
- scan_en  out  1  to filter scan_en
- scan_in  out  1  to filter scan_in
- scan_out  in  1  from filter scan_out
- readback_word  out  32  accumulator value displaced by the last preload
- readback_valid  out  1  one-cycle pulse when readback_word updates
- gain_sel  out  1  0 = FAST (acquire), 1 = SLOW (track)
- locked  out  1  high in TRACK state
- lock_lost  out  1  one-cycle pulse on TRACK→ACQUIRE
- busy  out  1  high during SHIFT

## Operation
- States: IDLE, SHIFT, ACQUIRE, TRACK.
- Event: `up ^ down`. Both high or both low is no event, matching the filter's zero error.
- IDLE: no monitoring.
  - cfg_load → SHIFT.
- SHIFT: 32 cycles with scan_en=1.
  - scan_in carries cfg_word MSB first, bit 31 first, so bit k lands at accumulator bit k.
  - Each cycle scan_out is shifted into a readback shift register (LSB in). After 32 cycles it holds the old accumulator.
  - Exit → ACQUIRE, loading readback_word and pulsing readback_valid.
- ACQUIRE: gain_sel=0.
  - The window counter runs. At each window end, a good window increments good_cnt; any other window clears it.
  - When good_cnt reaches N_GOOD → TRACK.
- TRACK: gain_sel=1, locked=1.
  - A bad window → ACQUIRE with lock_lost pulse.
  - Windows that are neither good nor bad: hold.
- cfg_load is accepted in IDLE, ACQUIRE and TRACK; it is ignored in SHIFT. Entering SHIFT from TRACK clears locked with no lock_lost pulse.
- Entry to ACQUIRE always clears the window counter, event counter and good_cnt.
- Event counter width is clog2(WIN_LEN+1). It cannot saturate within a window.

## Timing
- Reset values:
  - state=IDLE
  - scan_en=0, scan_in=0
  - readback_word=0, readback_valid=0
  - gain_sel=0, locked=0, lock_lost=0, busy=0
- Reset asserted mid-SHIFT: scan_en is 0 from the next edge. The partial readback is discarded.
- All outputs are registered.
- Preload: cfg_load accepted in cycle T.
  - scan_en=busy=1 in cycles T+1..T+32.
  - scan_in=cfg_word[31−k] in cycle T+1+k.
  - scan_out is sampled in those same cycles.
  - In cycle T+33: readback_valid=1, state=ACQUIRE, scan_en=0.
- Window: ACQUIRE entered in cycle E. The window covers cycles E..E+WIN_LEN−1, and an event in the last cycle counts.
  - The decision is visible at E+WIN_LEN: gain_sel/locked change and lock_lost pulses in that cycle.
  - The next window starts immediately, with no gap cycles.
- Lock earliest: N_GOOD·WIN_LEN cycles after ACQUIRE entry.
- cfg_load coinciding with a window-end decision: cfg_load wins, and the decision is discarded.

## Structure
- Package lpf_ctrl_pkg:
  - state enum (IDLE/SHIFT/ACQUIRE/TRACK)
  - gain_sel constants GAIN_FAST=0, GAIN_SLOW=1
  - SCAN_LEN=32
- Sub-module lock_window_mon: window counter plus event counter.
  - Inputs: clear, event.
  - Outputs: window_done pulse, good, bad flags.
- The top level holds the FSM, scan shifter/readback register and good_cnt.

## Test plan
- Preload 0xA5C3_1E0F into a filter model holding 0x1234_5678:
  - scan_en high exactly 32 cycles.
  - Filter accumulator = 0xA5C3_1E0F.
  - readback_word=0x1234_5678 with a single readback_valid pulse at T+33.
- No events after preload: locked rises exactly 8·64=512 cycles after ACQUIRE entry. gain_sel switches in the same cycle.
- Locked, then 17 up-only pulses in one window: lock_lost pulses and gain_sel=0 at window end. 16 pulses: stays locked.
- ACQUIRE with alternating windows of 3 and 5 events: good_cnt never exceeds 1, and no lock.
- up&down both high every cycle in ACQUIRE: treated as zero events, lock reached at 512 cycles.
- cfg_load during SHIFT is ignored. rst asserted at shift cycle 10 gives all outputs at reset values next cycle, and no readback_valid.
